twiddle_gen: RTL and testbench
==============================

Name: twiddle_gen

Overview:
- Parametrised twiddle-factor generator for the FFT datapath: returns W = cos(theta) - j*sin(theta), with theta = 2*pi*k/N.
- N is selectable at run time per request, up to 2^MAX_FFT_LENGTH_LOG2.
- Only a quarter-wave sine table is stored. Full-circle values come from correct quadrant symmetry.
- Adds a valid/ready pipeline with backpressure, per-request FFT length, an inverse (conjugate) mode, and a range-error flag. Sits between the FFT address sequencer and the butterfly multipliers.

Parameters:
- TWIDDLE_WIDTH, 16, signed two's-complement width of each of the real and imaginary parts.
- MAX_FFT_LENGTH_LOG2, 12, log2 of the largest supported N. Legal range is 3..16.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- reset_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  request valid.
- in_ready_o  output  1  request accepted on a cycle where in_valid_i && in_ready_o.
- k_i  input  MAX_FFT_LENGTH_LOG2  twiddle index k.
- len_log2_i  input  5  log2(N) for this request.
- inverse_i  input  1  1 selects W* = cos + j*sin (IFFT).
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer ready.
- data_o  output  2*TWIDDLE_WIDTH  {re, im}; re in the upper half.
- err_o  output  1  len_log2_i was out of range for this result; data_o is 0 when set.

Behaviour:
- Notation: M = MAX_FFT_LENGTH_LOG2, Q = 2^(M-2), A = 2^(TWIDDLE_WIDTH-1) - 1.
- Table: S[m] = round-half-away-from-zero(sin(2*pi*m/2^M) * A), for m = 0..Q inclusive (Q+1 entries). S[Q] = A.
  - Table contents are computed at elaboration; no init file.
  - The table is read at two addresses per cycle.
- Index mapping:
  - Legal request: 2 <= len_log2_i <= M.
  - Bits of k_i at and above len_log2_i are ignored (modulo N).
  - Scaled index: idx = (k_i masked) << (M - len_log2_i), M bits wide.
  - Quadrant q = idx[M-1:M-2]; offset m = idx[M-3:0].
- Symmetry (c = cos, s = sin):
  - q=0: c = S[Q-m], s = S[m].
  - q=1: c = -S[m], s = S[Q-m].
  - q=2: c = -S[Q-m], s = -S[m].
  - q=3: c = S[m], s = -S[Q-m].
- Output: re = c; im = -s when inverse_i=0, +s when inverse_i=1.
  - Negation never overflows, because the most negative code -2^(TWIDDLE_WIDTH-1) is never produced.
  - -0 = 0.
- Illegal len_log2_i (<2 or >M): err_o=1 and data_o=0 for that result. No sticky state.
- Pipeline: 2 stages.
  - Stage 1 registers idx, q, the inverse flag, the error flag and both table reads.
  - Stage 2 registers the signed, conjugated result.
- Advance/stall:
  - advance = !out_valid_o || out_ready_i.
  - in_ready_o = advance, which is purely combinational from the outputs.
  - When advance=1, both stages shift; stage-1 valid takes (in_valid_i && in_ready_o). Bubbles propagate as invalid.
  - When advance=0, all stage registers hold. data_o and err_o stay stable while out_valid_o=1 && !out_ready_i.
- Timing: latency 2 cycles from accept to out_valid_o when unstalled. Throughput 1 result per cycle under continuous out_ready_i.
- Ordering: results leave in request order. Each request's len_log2_i and inverse_i are captured at acceptance, so changing them between requests is legal.
- Reset: while reset_i=1, at the next edge both stage valids clear, out_valid_o=0, data_o=0, err_o=0. in_ready_o=1 from the first cycle after reset. In-flight requests are discarded, with no partial output after deassertion.

Test Plan:
All cases use TWIDDLE_WIDTH=16, M=12, out_ready_i=1 unless stated.
- k=0, len=12, inverse=0 -> 2 cycles later data_o=0x7FFF_0000, err_o=0.
- k=1024, len=12 -> data_o=0x0000_8001.
  - Same with inverse=1 -> 0x0000_7FFF.
  - k=2048 -> 0x8001_0000.
  - k=3072 -> 0x0000_7FFF.
- Runtime length: k=1, len=3 (idx=512, pi/4) -> data_o=0x5A82_A57E.
  - k=9, len=3 (masked to 1) gives the same result.
  - len=1 -> err_o=1, data_o=0.
- Streaming 4096 k values back-to-back:
  - One result per cycle, in order.
  - Every re/im matches the golden model within ±1 LSB.
  - re^2+im^2 lies within 32767^2 ± 2*32767.
- Backpressure: stream 8 requests while out_ready_i toggles in a pseudo-random pattern.
  - data_o stays stable during stalls.
  - No loss or duplication.
  - in_ready_o=0 exactly when out_valid_o && !out_ready_i.
- Reset mid-operation: assert reset_i for 1 cycle with 2 requests in flight.
  - Next cycle out_valid_o=0, data_o=0.
  - A fresh request after reset produces its correct result with 2-cycle latency.

Source files
------------

// File: rtl/twiddle_gen.sv
// Two-stage valid/ready twiddle-factor generator W = cos(theta) -/+ j*sin(theta).
// Only a quarter-wave sine table is stored; the full circle comes from quadrant symmetry.
module twiddle_gen #(
  parameter int unsigned TWIDDLE_WIDTH       = 16,
  parameter int unsigned MAX_FFT_LENGTH_LOG2 = 12
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [MAX_FFT_LENGTH_LOG2-1:0] k_i,
  input  logic [4:0]                   len_log2_i,
  input  logic                         inverse_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [2*TWIDDLE_WIDTH-1:0]   data_o,
  output logic                         err_o
);

  localparam int unsigned W  = TWIDDLE_WIDTH;
  localparam int unsigned M  = MAX_FFT_LENGTH_LOG2;
  localparam int unsigned Q  = 1 << (M - 2);
  localparam int unsigned A  = (1 << (W - 1)) - 1;
  localparam int unsigned AW = M - 1;

  // Rounded sin(2*pi*m/2^M)*A; all entries are non-negative so +0.5 then truncate rounds half away.
  function automatic logic [W-1:0] sin_entry(input int unsigned m);
    real angle;
    real scaled;
    angle  = 6.283185307179586 * real'(m) / (2.0 ** M);
    scaled = $sin(angle) * real'(A) + 0.5;
    return W'($rtoi(scaled));
  endfunction

  logic [W-1:0] w_sin_table [0:Q];

  for (genvar g = 0; g <= Q; g++) begin : g_table
    assign w_sin_table[g] = sin_entry(g);
  end

  logic          w_advance;
  logic [4:0]    w_shift;
  logic [M-1:0]  w_idx;
  logic [AW-1:0] w_addr_m;
  logic [AW-1:0] w_addr_qm;
  logic          w_err;

  logic          r_s1_valid;
  logic [1:0]    r_s1_q;
  logic          r_s1_inv;
  logic          r_s1_err;
  logic [W-1:0]  r_s1_sin_m;
  logic [W-1:0]  r_s1_sin_qm;

  logic [W-1:0]  w_c;
  logic [W-1:0]  w_s;
  logic [W-1:0]  w_im;

  logic                 r_out_valid;
  logic [2*W-1:0]       r_data;
  logic                 r_err;

  assign w_advance  = !r_out_valid || out_ready_i;
  assign in_ready_o = w_advance;

  // Shifting left inside an M-bit result drops the k bits at and above len_log2_i.
  assign w_shift   = 5'(M) - len_log2_i;
  assign w_idx     = k_i << w_shift;
  assign w_addr_m  = {1'b0, w_idx[M-3:0]};
  assign w_addr_qm = AW'(Q) - w_addr_m;
  assign w_err     = (len_log2_i < 5'd2) || (len_log2_i > 5'(M));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s1_valid  <= 1'b0;
      r_s1_q      <= '0;
      r_s1_inv    <= 1'b0;
      r_s1_err    <= 1'b0;
      r_s1_sin_m  <= '0;
      r_s1_sin_qm <= '0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid_i;
      r_s1_q      <= w_idx[M-1:M-2];
      r_s1_inv    <= inverse_i;
      r_s1_err    <= w_err;
      r_s1_sin_m  <= w_sin_table[w_addr_m];
      r_s1_sin_qm <= w_sin_table[w_addr_qm];
    end
  end

  // Quadrant symmetry, then conjugate for the inverse transform.
  always_comb begin
    w_c = '0;
    w_s = '0;
    case (r_s1_q)
      2'd0: begin
        w_c = r_s1_sin_qm;
        w_s = r_s1_sin_m;
      end
      2'd1: begin
        w_c = -r_s1_sin_m;
        w_s = r_s1_sin_qm;
      end
      2'd2: begin
        w_c = -r_s1_sin_qm;
        w_s = -r_s1_sin_m;
      end
      default: begin
        w_c = r_s1_sin_m;
        w_s = -r_s1_sin_qm;
      end
    endcase
    w_im = r_s1_inv ? w_s : -w_s;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= r_s1_valid;
      r_data      <= r_s1_err ? '0 : {w_c, w_im};
      r_err       <= r_s1_err;
    end
  end

  assign out_valid_o = r_out_valid;
  assign data_o      = r_data;
  assign err_o       = r_err;

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen: directed points, full-circle stream, backpressure, reset.
module tb_twiddle_gen;

  localparam int unsigned W = 16;
  localparam int unsigned M = 12;
  localparam longint      A = 32767;
  localparam real         PI = 3.14159265358979323846;

  logic           clk_i = 1'b0;
  logic           reset_i;
  logic           in_valid_i;
  logic           in_ready_o;
  logic [M-1:0]   k_i;
  logic [4:0]     len_log2_i;
  logic           inverse_i;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [2*W-1:0] data_o;
  logic           err_o;

  twiddle_gen #(.TWIDDLE_WIDTH(W), .MAX_FFT_LENGTH_LOG2(M)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .k_i         (k_i),
    .len_log2_i  (len_log2_i),
    .inverse_i   (inverse_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .data_o      (data_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint re;
    longint im;
    bit     err;
    longint tol;
    bit     chk_lat;
    longint cnt;
  } sb_t;

  sb_t    sb[$];
  int     n_checks = 0;
  int     n_errors = 0;
  longint cyc = 0;
  bit     mon_en = 0;
  bit     prev_stall = 0;
  logic [2*W-1:0] held_data;
  logic           held_err;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp, input longint tol = 0);
    longint d;
    n_checks++;
    d = obs - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  function automatic longint rnd(input real r);
    if (r >= 0.0) return longint'($rtoi($floor(r + 0.5)));
    return -longint'($rtoi($floor(-r + 0.5)));
  endfunction

  // Full-circle reference straight from cos/sin, independent of the quarter-table scheme.
  function automatic sb_t model(input int k, input int len, input bit inv);
    sb_t e;
    real th;
    longint s;
    int kk;
    e = '{re: 0, im: 0, err: 0, tol: 0, chk_lat: 0, cnt: 0};
    if (len < 2 || len > int'(M)) begin
      e.err = 1;
      return e;
    end
    kk   = k % (1 << len);
    th   = 2.0 * PI * real'(kk) / (2.0 ** len);
    e.re = rnd($cos(th) * real'(A));
    s    = rnd($sin(th) * real'(A));
    e.im = inv ? s : -s;
    e.tol = 1;
    return e;
  endfunction

  task automatic send(input int k, input int len, input bit inv, input sb_t e);
    in_valid_i = 1'b1;
    k_i        = M'(k);
    len_log2_i = 5'(len);
    inverse_i  = inv;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        e.cnt = cyc;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i);
      #1;
    end
    check("accept_timeout", 0, 1);
    in_valid_i = 1'b0;
  endtask

  task automatic send_exp(input int k, input int len, input bit inv, input logic [31:0] d, input bit err);
    sb_t e;
    e.re      = longint'($signed(d[31:16]));
    e.im      = longint'($signed(d[15:0]));
    e.err     = err;
    e.tol     = 0;
    e.chk_lat = 1;
    e.cnt     = 0;
    send(k, len, inv, e);
  endtask

  task automatic drain();
    for (int t = 0; t < 300; t++) begin
      if (sb.size() == 0) return;
      @(posedge clk_i);
      #1;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every transfer and checks handshake rules.
  always @(negedge clk_i) begin
    if (mon_en && !reset_i) begin
      check("in_ready", in_ready_o, !(out_valid_o && !out_ready_i));
      if (prev_stall && out_valid_o) begin
        check("stall_data", data_o, held_data);
        check("stall_err", err_o, held_err);
      end
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          check("extra_out", out_valid_o, 0);
        end else begin
          sb_t e;
          longint re, im;
          e  = sb.pop_front();
          re = longint'($signed(data_o[31:16]));
          im = longint'($signed(data_o[15:0]));
          check("err", err_o, e.err);
          check("re", re, e.re, e.tol);
          check("im", im, e.im, e.tol);
          if (!e.err) check("mag", re * re + im * im, A * A, 2 * A);
          if (e.chk_lat) check("latency", cyc - e.cnt, 2);
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      held_data  = data_o;
      held_err   = err_o;
    end else begin
      prev_stall = 0;
    end
  end

  initial begin
    reset_i     = 1'b1;
    in_valid_i  = 1'b0;
    k_i         = '0;
    len_log2_i  = 5'd12;
    inverse_i   = 1'b0;
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_valid", out_valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_err", err_o, 0);
    check("rst_ready", in_ready_o, 1);
    mon_en = 1;
    @(posedge clk_i);
    #1;

    send_exp(0,    12, 0, 32'h7FFF_0000, 0);
    send_exp(1024, 12, 0, 32'h0000_8001, 0);
    send_exp(1024, 12, 1, 32'h0000_7FFF, 0);
    send_exp(2048, 12, 0, 32'h8001_0000, 0);
    send_exp(3072, 12, 0, 32'h0000_7FFF, 0);
    send_exp(1,     3, 0, 32'h5A82_A57E, 0);
    send_exp(9,     3, 0, 32'h5A82_A57E, 0);
    send_exp(5,     1, 0, 32'h0000_0000, 1);
    send_exp(5,    13, 1, 32'h0000_0000, 1);
    send_exp(1,     2, 0, 32'h0000_8001, 0);
    send_exp(1,     3, 1, 32'h5A82_5A82, 0);
    drain();

    // Full circle, back to back; latency check per item enforces one result per cycle.
    for (int k = 0; k < 4096; k++) begin
      sb_t e;
      e = model(k, 12, k[0]);
      e.chk_lat = 1;
      send(k, 12, k[0], e);
    end
    drain();

    // Random backpressure with mixed lengths, including illegal ones.
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          int k, len;
          bit inv;
          k   = int'($urandom_range(0, 4095));
          len = int'($urandom_range(0, 15));
          inv = 1'($urandom_range(0, 1));
          send(k, len, inv, model(k, len, inv));
        end
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk_i);
          #1;
          out_ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready_i = 1'b1;
    drain();

    // Reset with two requests in flight while the output is stalled.
    out_ready_i = 1'b0;
    send_exp(1024, 12, 0, 32'h0000_8001, 0);
    send_exp(2048, 12, 0, 32'h8001_0000, 0);
    reset_i = 1'b1;
    sb.delete();
    @(posedge clk_i);
    #1;
    reset_i     = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("mid_rst_valid", out_valid_o, 0);
    check("mid_rst_data", data_o, 0);
    check("mid_rst_err", err_o, 0);
    @(posedge clk_i);
    #1;
    send_exp(3072, 12, 1, 32'h0000_8001, 0);
    drain();
    repeat (4) @(posedge clk_i);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
